// File: rtl/slave_addr_fifo_wr_arbiter.sv
// Purpose: round-robin arbiter sharing the address FIFO write port between AW and AR, with a per-source burst quota and almost-full throttle.
// Latency: a request accepted at edge N is presented with w_en=1 in cycle N+1 (when wfull=0); one entry per cycle sustained.
// Backpressure: readies drop while the holding register cannot drain (wfull), during throttle gaps and while wrst is high.
module slave_addr_fifo_wr_arbiter #(
  parameter int c_DATA_WIDTH   = 32,
  parameter int c_QUOTA        = 4,
  parameter int c_THROTTLE_GAP = 3
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic                    aw_valid,
  input  logic [c_DATA_WIDTH-1:0] aw_data,
  output logic                    aw_ready,
  input  logic                    ar_valid,
  input  logic [c_DATA_WIDTH-1:0] ar_data,
  output logic                    ar_ready,
  input  logic                    wfull,
  input  logic                    almost_full,
  output logic                    w_en,
  output logic [c_DATA_WIDTH:0]   fifo_wdata
);

  localparam logic [3:0] QUOTA = 4'(c_QUOTA);
  localparam logic [3:0] GAP   = 4'(c_THROTTLE_GAP);
  localparam logic       SRC_AW = 1'b0;

  logic                  hv_q, hv_d;
  logic [c_DATA_WIDTH:0] hdata_q, hdata_d;
  logic                  last_q, last_d;
  logic [3:0]            run_cnt_q, run_cnt_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;

  logic                    can_accept;
  logic                    winner;
  logic                    keep_last;
  logic                    accept;
  logic [c_DATA_WIDTH-1:0] payload;

  // Output drive, admission check and winner selection.
  // A zero run count means no streak exists yet (only right after reset), so the
  // pointer side yields and the other source (AW out of reset) wins first.
  always_comb begin
    w_en       = hv_q & ~wfull;
    fifo_wdata = hdata_q;
    can_accept = (~hv_q | w_en) & (gap_cnt_q == 4'd0) & ~wrst;
    keep_last  = (run_cnt_q != 4'd0) && (run_cnt_q < QUOTA);
    winner     = SRC_AW;
    if (aw_valid && ar_valid) begin
      winner = keep_last ? last_q : ~last_q;
    end else if (ar_valid) begin
      winner = 1'b1;
    end
    aw_ready = can_accept & aw_valid & (winner == SRC_AW);
    ar_ready = can_accept & ar_valid & (winner != SRC_AW);
    accept   = aw_ready | ar_ready;
    payload  = (winner == SRC_AW) ? aw_data : ar_data;
  end

  // Next-state: holding register, round-robin bookkeeping and throttle counter.
  always_comb begin
    hv_d      = hv_q & ~w_en;
    hdata_d   = hdata_q;
    last_d    = last_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (accept) begin
      hv_d    = 1'b1;
      hdata_d = {winner, payload};
      if (winner == last_q) begin
        run_cnt_d = (run_cnt_q == 4'hF) ? 4'hF : run_cnt_q + 4'd1;
      end else begin
        run_cnt_d = 4'd1;
        last_d    = winner;
      end
    end
    if (!almost_full) begin
      gap_cnt_d = 4'd0;
    end else if (accept) begin
      gap_cnt_d = GAP;
    end else if (gap_cnt_q != 4'd0) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end
  end

  // State registers; reset drops any held entry and points last at AR.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      hv_q      <= 1'b0;
      hdata_q   <= '0;
      last_q    <= 1'b1;
      run_cnt_q <= 4'd0;
      gap_cnt_q <= 4'd0;
    end else begin
      hv_q      <= hv_d;
      hdata_q   <= hdata_d;
      last_q    <= last_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_slave_addr_fifo_wr_arbiter.sv
// Purpose: directed table-driven check of the AW/AR write-port arbiter plus a strict-alternation sequence.
// Latency: inputs change at the falling edge, outputs are compared 1ns later.
// Backpressure: wfull and almost_full are driven from the vector table.
module tb_slave_addr_fifo_wr_arbiter;

  localparam int W = 32;

  logic         wclk = 1'b0;
  logic         wrst;
  logic         aw_valid, ar_valid, wfull, almost_full;
  logic [W-1:0] aw_data, ar_data;
  logic         aw_ready, ar_ready, w_en;
  logic [W:0]   fifo_wdata;
  logic         aw_ready1, ar_ready1, w_en1;
  logic [W:0]   fifo_wdata1;

  always #5 wclk = ~wclk;

  slave_addr_fifo_wr_arbiter #(.c_DATA_WIDTH(W), .c_QUOTA(2), .c_THROTTLE_GAP(3)) dut (
    .wclk(wclk), .wrst(wrst),
    .aw_valid(aw_valid), .aw_data(aw_data), .aw_ready(aw_ready),
    .ar_valid(ar_valid), .ar_data(ar_data), .ar_ready(ar_ready),
    .wfull(wfull), .almost_full(almost_full),
    .w_en(w_en), .fifo_wdata(fifo_wdata)
  );

  slave_addr_fifo_wr_arbiter #(.c_DATA_WIDTH(W), .c_QUOTA(1), .c_THROTTLE_GAP(0)) dut1 (
    .wclk(wclk), .wrst(wrst),
    .aw_valid(aw_valid), .aw_data(aw_data), .aw_ready(aw_ready1),
    .ar_valid(ar_valid), .ar_data(ar_data), .ar_ready(ar_ready1),
    .wfull(wfull), .almost_full(almost_full),
    .w_en(w_en1), .fifo_wdata(fifo_wdata1)
  );

  typedef struct {
    logic       rst, awv, arv, wf, af;
    logic       awr, arr, wen;
    logic [W:0] wd;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [W:0] fa(input int k);
    return {1'b0, 32'hA000_0000 + 32'(k)};
  endfunction

  function automatic logic [W:0] fb(input int k);
    return {1'b1, 32'hB000_0000 + 32'(k)};
  endfunction

  task automatic add(input logic rst, input logic awv, input logic arv, input logic wf,
                     input logic af, input logic awr, input logic arr, input logic wen,
                     input logic [W:0] wd);
    vec_t v;
    v.rst = rst; v.awv = awv; v.arv = arv; v.wf = wf; v.af = af;
    v.awr = awr; v.arr = arr; v.wen = wen; v.wd = wd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    // Columns: rst awv arv wf af | aw_ready ar_ready w_en fifo_wdata (quota 2, gap 3)
    add(1, 1, 0, 0, 0, 0, 0, 0, '0);            // 0  reset: readies low
    add(0, 1, 0, 0, 0, 1, 0, 0, '0);            // 1  single AW accepted
    add(0, 0, 0, 0, 0, 0, 0, 1, fa(1));         // 2  written next cycle
    add(0, 0, 0, 0, 0, 0, 0, 0, fa(1));         // 3  drained, data held
    add(0, 1, 1, 0, 0, 1, 0, 0, fa(1));         // 4  AW (second of streak)
    add(0, 1, 1, 0, 0, 0, 1, 1, fa(4));         // 5  quota hit -> AR
    add(0, 1, 1, 0, 0, 0, 1, 1, fb(5));         // 6  AR
    add(0, 1, 1, 0, 0, 1, 0, 1, fb(6));         // 7  AW
    add(0, 1, 1, 0, 0, 1, 0, 1, fa(7));         // 8  AW
    add(0, 1, 1, 0, 0, 0, 1, 1, fa(8));         // 9  AR
    for (int i = 10; i <= 14; i++)
      add(0, 1, 0, 1, 0, 0, 0, 0, fb(9));       // 10-14 wfull stalls
    add(0, 0, 0, 0, 0, 0, 0, 1, fb(9));         // 15 drain after wfull falls
    add(0, 0, 0, 0, 0, 0, 0, 0, fb(9));         // 16
    add(0, 0, 1, 0, 1, 0, 1, 0, fb(9));         // 17 throttle cycle 0 accept
    add(0, 0, 1, 0, 1, 0, 0, 1, fb(17));        // 18
    add(0, 0, 1, 0, 1, 0, 0, 0, fb(17));        // 19
    add(0, 0, 1, 0, 1, 0, 0, 0, fb(17));        // 20
    add(0, 0, 1, 0, 1, 0, 1, 0, fb(17));        // 21 cycle 4 accept
    add(0, 0, 1, 0, 1, 0, 0, 1, fb(21));        // 22
    add(0, 0, 1, 0, 1, 0, 0, 0, fb(21));        // 23
    add(0, 0, 1, 0, 1, 0, 0, 0, fb(21));        // 24
    add(0, 0, 1, 0, 1, 0, 1, 0, fb(21));        // 25 cycle 8 accept
    add(0, 0, 1, 0, 0, 0, 0, 1, fb(25));        // 26 almost_full drops
    add(0, 0, 1, 0, 0, 0, 1, 0, fb(25));        // 27 accepts resume
    add(0, 0, 1, 0, 0, 0, 1, 1, fb(27));        // 28
    add(0, 1, 0, 0, 0, 1, 0, 1, fb(28));        // 29 AW loaded
    add(0, 1, 0, 1, 0, 0, 0, 0, fa(29));        // 30 held by wfull
    add(1, 1, 0, 1, 0, 0, 0, 0, fa(29));        // 31 reset discards it
    add(0, 1, 1, 0, 0, 1, 0, 0, '0);            // 32 AW wins first contention
    add(0, 1, 1, 0, 0, 1, 0, 1, fa(32));        // 33
    add(0, 0, 0, 0, 0, 0, 0, 1, fa(33));        // 34

    wrst = 1'b1; aw_valid = 1'b0; ar_valid = 1'b0; wfull = 1'b0; almost_full = 1'b0;
    aw_data = '0; ar_data = '0;
    repeat (2) @(negedge wclk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge wclk);
      wrst        = vecs[k].rst;
      aw_valid    = vecs[k].awv;
      ar_valid    = vecs[k].arv;
      wfull       = vecs[k].wf;
      almost_full = vecs[k].af;
      aw_data     = 32'hA000_0000 + 32'(k);
      ar_data     = 32'hB000_0000 + 32'(k);
      #1;
      chk("aw_ready", k, {32'd0, aw_ready}, {32'd0, vecs[k].awr});
      chk("ar_ready", k, {32'd0, ar_ready}, {32'd0, vecs[k].arr});
      chk("w_en", k, {32'd0, w_en}, {32'd0, vecs[k].wen});
      chk("fifo_wdata", k, fifo_wdata, vecs[k].wd);
    end

    // Quota 1: strict alternation starting with AW, source tag toggles per write.
    @(negedge wclk);
    wrst = 1'b1; aw_valid = 1'b0; ar_valid = 1'b0; wfull = 1'b0; almost_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      wrst     = 1'b0;
      aw_valid = (i < 4);
      ar_valid = (i < 4);
      #1;
      if (i < 4) begin
        chk("alt_aw_ready", i, {32'd0, aw_ready1}, {32'd0, (i % 2) == 0});
        chk("alt_ar_ready", i, {32'd0, ar_ready1}, {32'd0, (i % 2) == 1});
      end
      if (i > 0) begin
        chk("alt_w_en", i, {32'd0, w_en1}, {32'd0, 1'b1});
        chk("alt_src", i, {32'd0, fifo_wdata1[W]}, {32'd0, ((i - 1) % 2) == 1});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
